// File: rtl/lstm_axi_pkg.sv
// Shared types and constants for the LSTM stream feeder and the LSTM wrapper's
// register decoder: sequencer states, AXI response codes, default address map.
package lstm_axi_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR      = 4'd1,
    S_WR_B    = 4'd2,
    S_START   = 4'd3,
    S_START_B = 4'd4,
    S_POLL_AR = 4'd5,
    S_POLL_R  = 4'd6,
    S_RD_AR   = 4'd7,
    S_RD_R    = 4'd8,
    S_OUT     = 4'd9
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] DEF_IN_BASE     = 32'h0000_0000;
  localparam logic [31:0] DEF_CTRL_ADDR   = 32'h0000_1000;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_1004;
  localparam logic [31:0] DEF_OUT_BASE    = 32'h0000_2000;

  // Byte address of 32-bit word idx in a window starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/axi4_lite_master_if.sv
// Single-transaction AXI4-Lite master engine: one write (AW+W then B) or one read
// (AR then R) per request pulse, with address-phase and completion strobes.
module axi4_lite_master_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_req,
  input  logic        i_rd_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_done,
  output logic        o_done,
  output logic [1:0]  o_resp,
  output logic [31:0] o_rdata,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awprot,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic [31:0] o_araddr,
  output logic [2:0]  o_arprot,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready
);

  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_wr_act;
  logic [31:0] r_awaddr, r_wdata, r_araddr;
  logic        w_wr_addr_done, w_rd_addr_done, w_b_done, w_r_done;

  // AW and W may complete in different cycles; a dropped valid marks its channel as done.
  assign w_wr_addr_done = r_wr_act & (~r_awvalid | i_awready) & (~r_wvalid | i_wready);
  assign w_rd_addr_done = r_arvalid & i_arready;
  assign w_b_done       = r_bready & i_bvalid;
  assign w_r_done       = r_rready & i_rvalid;

  assign o_addr_done = w_wr_addr_done | w_rd_addr_done;
  assign o_done      = w_b_done | w_r_done;
  assign o_resp      = w_r_done ? i_rresp : i_bresp;
  assign o_rdata     = i_rdata;

  assign o_awaddr  = r_awaddr;
  assign o_awprot  = 3'b000;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = 4'hF;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;
  assign o_araddr  = r_araddr;
  assign o_arprot  = 3'b000;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

  // Channel valid/ready registers and the address/data held stable while valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_wr_act  <= 1'b0;
      r_awaddr  <= 32'h0;
      r_wdata   <= 32'h0;
      r_araddr  <= 32'h0;
    end else begin
      if (i_wr_req) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_wr_act  <= 1'b1;
        r_awaddr  <= i_addr;
        r_wdata   <= i_wdata;
      end else begin
        if (r_awvalid && i_awready) r_awvalid <= 1'b0;
        if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
        if (w_wr_addr_done)         r_wr_act  <= 1'b0;
      end
      if (w_wr_addr_done)  r_bready <= 1'b1;
      else if (w_b_done)   r_bready <= 1'b0;
      if (i_rd_req) begin
        r_arvalid <= 1'b1;
        r_araddr  <= i_addr;
      end else if (w_rd_addr_done) begin
        r_arvalid <= 1'b0;
      end
      if (w_rd_addr_done)  r_rready <= 1'b1;
      else if (w_r_done)   r_rready <= 1'b0;
    end
  end

endmodule

// File: rtl/lstm_stream_feeder.sv
// Streams an input vector into the LSTM input window over AXI4-Lite, starts the
// inference, polls for done and streams the result window back out.
module lstm_stream_feeder
  import lstm_axi_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH       = 512,
  parameter int          OUT_WORDS   = 16,
  parameter logic [31:0] IN_BASE     = DEF_IN_BASE,
  parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [31:0] OUT_BASE    = DEF_OUT_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [31:0]      awaddr,
  output logic [2:0]       awprot,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wvalid,
  input  logic             wready,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic [31:0]      araddr,
  output logic [2:0]       arprot,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic             busy,
  output logic             err
);

  localparam int             IW       = $clog2(DEPTH);
  localparam logic [IW-1:0]  IDX_MAX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0]  OUT_LAST = IW'(OUT_WORDS - 1);

  state_e           r_state, w_next;
  logic [IW-1:0]    r_idx, r_ocnt;
  logic             r_last, r_err, r_busy, r_s_tready, r_m_tvalid, r_m_tlast;
  logic [WIDTH-1:0] r_m_tdata;
  logic             w_wr_req, w_rd_req, w_addr_done, w_done, w_accept, w_out_hs;
  logic [31:0]      w_req_addr, w_req_data, w_rdata;
  logic [1:0]       w_resp;

  assign w_accept = r_s_tready & s_axis_tvalid;
  assign w_out_hs = r_m_tvalid & m_axis_tready;

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign busy          = r_busy;
  assign err           = r_err;

  axi4_lite_master_if u_axi (
    .clk(clk), .rst(rst),
    .i_wr_req(w_wr_req), .i_rd_req(w_rd_req), .i_addr(w_req_addr), .i_wdata(w_req_data),
    .o_addr_done(w_addr_done), .o_done(w_done), .o_resp(w_resp), .o_rdata(w_rdata),
    .o_awaddr(awaddr), .o_awprot(awprot), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arprot(arprot), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
  );

  // Sequencer next state; requests are issued on the transition into each request state.
  always_comb begin
    w_next     = r_state;
    w_wr_req   = 1'b0;
    w_rd_req   = 1'b0;
    w_req_addr = word_addr(IN_BASE, 32'(r_idx));
    w_req_data = s_axis_tdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next   = S_WR;
          w_wr_req = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR:      if (w_addr_done) w_next = S_WR_B;    else w_next = S_WR;
      S_WR_B: begin
        if (w_done && r_last) begin
          w_next     = S_START;
          w_wr_req   = 1'b1;
          w_req_addr = CTRL_ADDR;
          w_req_data = 32'h0000_0001;
        end else if (w_done) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_WR_B;
        end
      end
      S_START:   if (w_addr_done) w_next = S_START_B; else w_next = S_START;
      S_START_B: begin
        if (w_done) begin
          w_next     = S_POLL_AR;
          w_rd_req   = 1'b1;
          w_req_addr = STATUS_ADDR;
        end else begin
          w_next = S_START_B;
        end
      end
      S_POLL_AR: if (w_addr_done) w_next = S_POLL_R;  else w_next = S_POLL_AR;
      S_POLL_R: begin
        if (w_done && w_rdata[0]) begin
          w_next     = S_RD_AR;
          w_rd_req   = 1'b1;
          w_req_addr = OUT_BASE;
        end else if (w_done) begin
          w_next     = S_POLL_AR;
          w_rd_req   = 1'b1;
          w_req_addr = STATUS_ADDR;
        end else begin
          w_next = S_POLL_R;
        end
      end
      S_RD_AR:   if (w_addr_done) w_next = S_RD_R;    else w_next = S_RD_AR;
      S_RD_R:    if (w_done)      w_next = S_OUT;     else w_next = S_RD_R;
      S_OUT: begin
        if (w_out_hs && r_m_tlast) begin
          w_next = S_IDLE;
        end else if (w_out_hs) begin
          w_next     = S_RD_AR;
          w_rd_req   = 1'b1;
          w_req_addr = word_addr(OUT_BASE, 32'(r_ocnt + IW'(1)));
        end else begin
          w_next = S_OUT;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // State register, counters, sticky error and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_ocnt     <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
    end else begin
      r_state    <= w_next;
      r_s_tready <= (w_next == S_IDLE);
      r_busy     <= (w_next != S_IDLE);
      r_m_tvalid <= (w_next == S_OUT);
      r_m_tlast  <= (w_next == S_OUT) && (r_ocnt == OUT_LAST);
      if (w_accept) begin
        r_last <= s_axis_tlast;
        if (r_idx == IDX_MAX && !s_axis_tlast) r_err <= 1'b1;
      end
      if (w_done && w_resp != RESP_OKAY) r_err <= 1'b1;
      // Index saturates at the last slot; overflow words keep overwriting it.
      if (r_state == S_WR_B && w_done) begin
        if (r_last)                r_idx <= '0;
        else if (r_idx != IDX_MAX) r_idx <= r_idx + IW'(1);
      end
      if (r_state == S_POLL_R && w_done && w_rdata[0])     r_ocnt <= '0;
      if (r_state == S_OUT && w_out_hs && !r_m_tlast)      r_ocnt <= r_ocnt + IW'(1);
      if (r_state == S_RD_R && w_done)                     r_m_tdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_lstm_stream_feeder.sv
// Directed bench for lstm_stream_feeder with a behavioural AXI4-Lite slave
// (configurable AW delay, error response and poll count) and stream monitors.
module tb_lstm_stream_feeder;
  import lstm_axi_pkg::*;

  localparam int OUT_WORDS = 16;
  localparam int LIM       = 3000;

  typedef struct {
    int   nw;
    int   awd;
    int   errw;
    int   pz;
    logic exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, busy, err;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  lstm_stream_feeder dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy), .err(err)
  );

  // Slave configuration and state
  int          aw_delay = 0, err_word = -1, poll_zeros = 0;
  int          aw_cnt, wr_idx, poll_seen;
  logic        have_aw, have_w;
  logic [31:0] lat_awaddr, lat_wdata;
  logic        aw_hs_now, w_hs_now;

  // Logs written only by the monitor processes
  logic [31:0] wa_q[$], wd_q[$], ra_q[$], od_q[$];
  logic        ol_q[$];
  int          acc_q[$];
  int          cyc = 0, aw_hs = 0, w_hs = 0;

  int n_cmp = 0, n_bad = 0;

  assign awready   = awvalid && (aw_cnt >= aw_delay);
  assign wready    = wvalid;
  assign arready   = arvalid;
  assign aw_hs_now = awvalid & awready;
  assign w_hs_now  = wvalid & wready;

  // Behavioural AXI4-Lite slave; logs each completed write and every read address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
      aw_cnt <= 0; have_aw <= 1'b0; have_w <= 1'b0; wr_idx <= 0; poll_seen <= 0;
      lat_awaddr <= 32'h0; lat_wdata <= 32'h0;
    end else begin
      if (aw_hs_now) aw_cnt <= 0;
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (aw_hs_now) lat_awaddr <= awaddr;
      if (w_hs_now)  lat_wdata  <= wdata;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((have_aw || aw_hs_now) && (have_w || w_hs_now)) begin
        wa_q.push_back(aw_hs_now ? awaddr : lat_awaddr);
        wd_q.push_back(w_hs_now ? wdata : lat_wdata);
        bvalid  <= 1'b1;
        bresp   <= (wr_idx == err_word) ? RESP_SLVERR : RESP_OKAY;
        wr_idx  <= wr_idx + 1;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
      end else begin
        if (aw_hs_now) have_aw <= 1'b1;
        if (w_hs_now)  have_w  <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ra_q.push_back(araddr);
        rvalid <= 1'b1;
        rresp  <= RESP_OKAY;
        if (araddr == 32'h0000_1004) begin
          rdata     <= (poll_seen >= poll_zeros) ? 32'h1 : 32'h0;
          poll_seen <= poll_seen + 1;
        end else begin
          rdata <= 32'hA000_0000 + ((araddr - 32'h0000_2000) >> 32'd2);
        end
      end
    end
  end

  // Stream-side and handshake monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_hs_now) aw_hs <= aw_hs + 1;
    if (w_hs_now)  w_hs  <= w_hs + 1;
    if (s_axis_tvalid && s_axis_tready) acc_q.push_back(cyc);
    if (m_axis_tvalid && m_axis_tready) begin
      od_q.push_back(m_axis_tdata);
      ol_q.push_back(m_axis_tlast);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valids", {28'h0, awvalid, wvalid, arvalid, m_axis_tvalid}, 32'h0);
    check("rst_rdy_busy_err", {28'h0, bready, rready, busy, err}, 32'h0);
    check("rst_tready", {31'h0, s_axis_tready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", {31'h0, s_axis_tready}, 32'h1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!s_axis_tready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'h0, (n >= LIM)}, 32'h0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int b_od);
    int n;
    n = 0;
    while (((od_q.size() - b_od) < OUT_WORDS || busy) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'h0, (n >= LIM)}, 32'h0);
  endtask

  task automatic check_outputs(input int b_od);
    check("out_count", 32'(od_q.size() - b_od), 32'(OUT_WORDS));
    for (int k = 0; k < OUT_WORDS && (b_od + k) < od_q.size(); k++) begin
      check($sformatf("out_data[%0d]", k), od_q[b_od + k], 32'hA000_0000 + 32'(k));
      check($sformatf("out_last[%0d]", k), {31'h0, ol_q[b_od + k]}, {31'h0, (k == OUT_WORDS - 1)});
    end
  endtask

  vec_t vecs[4];

  initial begin
    int b_wa, b_ra, b_od, b_acc, b_aw, b_w, nst, nrd;
    logic [31:0] d0;
    vecs[0] = '{4, 0, -1, 3, 1'b0};
    vecs[1] = '{4, 2, -1, 0, 1'b0};
    vecs[2] = '{5, 0,  1, 1, 1'b1};
    vecs[3] = '{1, 0, -1, 0, 1'b0};

    for (int vi = 0; vi < 4; vi++) begin
      aw_delay = vecs[vi].awd; err_word = vecs[vi].errw; poll_zeros = vecs[vi].pz;
      m_axis_tready = 1'b1;
      do_reset();
      b_wa = wa_q.size(); b_ra = ra_q.size(); b_od = od_q.size(); b_acc = acc_q.size();
      b_aw = aw_hs; b_w = w_hs;
      for (int k = 0; k < vecs[vi].nw; k++)
        send_word(32'(vi * 256 + k + 1), (k == vecs[vi].nw - 1));
      wait_done(b_od);

      check($sformatf("v%0d_wr_count", vi), 32'(wa_q.size() - b_wa), 32'(vecs[vi].nw + 1));
      check($sformatf("v%0d_aw_beats", vi), 32'(aw_hs - b_aw), 32'(vecs[vi].nw + 1));
      check($sformatf("v%0d_w_beats", vi), 32'(w_hs - b_w), 32'(vecs[vi].nw + 1));
      for (int k = 0; k <= vecs[vi].nw && (b_wa + k) < wa_q.size(); k++) begin
        if (k < vecs[vi].nw) begin
          check($sformatf("v%0d_wr_addr[%0d]", vi, k), wa_q[b_wa + k], 32'(4 * k));
          check($sformatf("v%0d_wr_data[%0d]", vi, k), wd_q[b_wa + k], 32'(vi * 256 + k + 1));
        end else begin
          check($sformatf("v%0d_start_addr", vi), wa_q[b_wa + k], 32'h0000_1000);
          check($sformatf("v%0d_start_data", vi), wd_q[b_wa + k], 32'h0000_0001);
        end
      end
      nst = 0;
      for (int k = b_ra; k < ra_q.size(); k++)
        if (ra_q[k] == 32'h0000_1004) nst++;
      check($sformatf("v%0d_status_reads", vi), 32'(nst), 32'(vecs[vi].pz + 1));
      nrd = vecs[vi].pz + 1;
      check($sformatf("v%0d_rd_count", vi), 32'(ra_q.size() - b_ra), 32'(nrd + OUT_WORDS));
      for (int k = 0; k < OUT_WORDS && (b_ra + nrd + k) < ra_q.size(); k++)
        check($sformatf("v%0d_rd_addr[%0d]", vi, k), ra_q[b_ra + nrd + k], 32'h0000_2000 + 32'(4 * k));
      check_outputs(b_od);
      check($sformatf("v%0d_err", vi), {31'h0, err}, {31'h0, vecs[vi].exp_err});
      check($sformatf("v%0d_idle", vi), {30'h0, busy, s_axis_tready}, 32'h1);
      if (vi == 0) begin
        for (int k = 1; k < vecs[vi].nw && (b_acc + k) < acc_q.size(); k++)
          check($sformatf("word_period[%0d]", k), 32'(acc_q[b_acc + k] - acc_q[b_acc + k - 1]), 32'd3);
      end
    end

    // Output back-pressure: data held, no further AR, busy stays high.
    aw_delay = 0; err_word = -1; poll_zeros = 0;
    m_axis_tready = 1'b0;
    do_reset();
    b_od = od_q.size();
    send_word(32'h0000_0055, 1'b1);
    begin
      int n;
      n = 0;
      while (!m_axis_tvalid && n < LIM) begin
        @(negedge clk);
        n++;
      end
      check("stall_tvalid_timeout", {31'h0, (n >= LIM)}, 32'h0);
    end
    d0  = m_axis_tdata;
    nrd = ra_q.size();
    check("stall_first_data", d0, 32'hA000_0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
      check("stall_tdata", m_axis_tdata, d0);
      check("stall_busy", {31'h0, busy}, 32'h1);
    end
    check("stall_no_ar", 32'(ra_q.size()), 32'(nrd));
    m_axis_tready = 1'b1;
    wait_done(b_od);
    check_outputs(b_od);

    // Reset while waiting on a status read, then a fresh 1-word packet.
    poll_zeros = 1000;
    do_reset();
    send_word(32'h0000_0007, 1'b1);
    begin
      int n;
      n = 0;
      while (!rready && n < LIM) begin
        @(negedge clk);
        n++;
      end
      check("poll_r_timeout", {31'h0, (n >= LIM)}, 32'h0);
    end
    rst = 1'b1;
    #1;
    check("midrst_valids", {28'h0, awvalid, wvalid, arvalid, m_axis_tvalid}, 32'h0);
    check("midrst_rdy", {28'h0, bready, rready, busy, s_axis_tready}, 32'h0);
    @(negedge clk);
    poll_zeros = 0;
    rst = 1'b0;
    @(negedge clk);
    b_wa = wa_q.size(); b_od = od_q.size();
    send_word(32'h0000_0099, 1'b1);
    wait_done(b_od);
    check("post_rst_wr_count", 32'(wa_q.size() - b_wa), 32'd2);
    if (wa_q.size() > b_wa) begin
      check("post_rst_addr", wa_q[b_wa], 32'h0000_0000);
      check("post_rst_data", wd_q[b_wa], 32'h0000_0099);
    end
    check_outputs(b_od);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lstm_stream_feeder.md
# lstm_stream_feeder

Upstream AXI4-Lite master for the LSTM layer stack. Accepts an input vector as an AXI-Stream packet, writes it word by word into the LSTM input address window, writes the start register, polls the status register until done, then reads the result window and emits it as an output AXI-Stream packet. It connects directly to the slave port of the AXI4-Lite LSTM layers wrapper and replaces host-driven register access with a streaming front end.

## Interface
- WIDTH, 32: data word width. Must equal 32, matching the AXI4-Lite data bus.
- DEPTH, 512: maximum input words per packet.
- OUT_WORDS, 16: result words read per inference, range 1..DEPTH.
- IN_BASE, 32'h0000_0000: byte address of input word 0.
- CTRL_ADDR, 32'h0000_1000: start register. Writing 1 starts an inference.
- STATUS_ADDR, 32'h0000_1004: status register. Bit 0 is done.
- OUT_BASE, 32'h0000_2000: byte address of result word 0.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- s_axis_tdata, in, 32: input word.
- s_axis_tvalid, in, 1: input word valid.
- s_axis_tlast, in, 1: last input word of the vector.
- s_axis_tready, out, 1: input word accepted.
- m_axis_tdata, out, 32: result word.
- m_axis_tvalid, out, 1: result word valid.
- m_axis_tlast, out, 1: last result word.
- m_axis_tready, in, 1: result sink ready.
- awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-Lite master.
  - Widths are 32/3/1/1, 32/4/1/1, 2/1/1, 32/3/1/1, 32/2/1/1.
  - All directions are mirrored from the slave.
- busy, out, 1: high in every state except S_IDLE.
- err, out, 1: sticky error flag. Cleared only by reset.

## Operation
- States: S_IDLE, S_WR, S_WR_B, S_START, S_START_B, S_POLL_AR, S_POLL_R, S_RD_AR, S_RD_R, S_OUT.
- At most one AXI transaction is outstanding at any time.
- awprot and arprot are always 0. wstrb is always 4'hF.
- **S_IDLE:** s_axis_tready is 1.
  - On tvalid&tready, latch the word and its tlast, then go to S_WR.
  - Target address is IN_BASE + 4·idx. idx is a $clog2(DEPTH)-bit word counter.
- **S_WR:** assert awvalid and wvalid together.
  - Each valid drops independently on its own handshake.
  - Once both handshakes have completed, go to S_WR_B.
- **S_WR_B:** bready is 1. On bvalid:
  - If tlast was latched, go to S_START and clear idx.
  - Otherwise increment idx and return to S_IDLE.
- **S_START / S_START_B:** same as S_WR / S_WR_B, writing 32'h1 to CTRL_ADDR. Then go to S_POLL_AR.
- **S_POLL_AR:** assert arvalid with araddr = STATUS_ADDR. On arready, go to S_POLL_R.
- **S_POLL_R:** rready is 1. On rvalid:
  - rdata[0]=1: go to S_RD_AR with the output counter ocnt=0.
  - rdata[0]=0: return to S_POLL_AR on the next cycle.
- **S_RD_AR:** assert arvalid with araddr = OUT_BASE + 4·ocnt. On arready, go to S_RD_R.
- **S_RD_R:** rready is 1. On rvalid, load m_axis_tdata and go to S_OUT.
- **S_OUT:** m_axis_tvalid is 1 and m_axis_tlast = (ocnt==OUT_WORDS-1). On tready:
  - If last, go to S_IDLE.
  - Otherwise increment ocnt and go to S_RD_AR.
- Errors:
  - Any bresp or rresp ≠ 2'b00 sets err. The sequence continues unchanged.
  - Overflow: a word accepted while idx==DEPTH-1 without tlast sets err. That word is written at index DEPTH-1, and idx saturates.
  - Subsequent words overwrite index DEPTH-1 until tlast arrives.
- Master outputs are registered. awaddr, wdata and araddr are stable while their valid is high.

## Timing
- Reset values: all valids 0, bready 0, rready 0, s_axis_tready 0, m_axis outputs 0, busy 0, err 0. State is S_IDLE.
- After rst deasserts, s_axis_tready rises on the first clock edge.
- Input word throughput with zero-wait slave (awready=wready=bvalid immediate): 3 cycles/word.
  - Cycle 1: accept. Cycle 2: AW+W. Cycle 3: B.
- Poll loop: 2 cycles per poll with a zero-wait slave.
- Result words: 3 cycles each (AR, R, OUT), assuming m_axis_tready is held high.
- A reset mid-transaction drops all valids asynchronously and abandons the transfer. The slave is also reset by the same rst.
- awready and wready arriving in different cycles must both be honoured. The state must not advance until both have occurred.

## Structure
- Package lstm_axi_pkg holds:
  - the state enum;
  - AXI response codes (OKAY=2'b00, SLVERR=2'b10);
  - default address constants shared with the LSTM wrapper's decoder.
- A natural sub-module is axi4_lite_master_if. It is a single-transaction engine for one write or one read, with request/done/resp handshake.
  - The sequencing FSM drives it for all writes and reads.

## Test plan
- 4-word packet (1,2,3,4, tlast on 4) with a zero-wait slave → writes 1,2,3,4 to 0x0, 0x4, 0x8, 0xC, then 1 to 0x1000. Timing is 3 cycles/word.
- Status returns 0 three times, then 1 → exactly 4 reads of 0x1004, then OUT_WORDS reads starting at 0x2000. m_axis_tlast is set only on word 15.
- awready delayed 2 cycles relative to wready → a single write per word, wvalid low after its handshake, no duplicate beats.
- Slave returns bresp=SLVERR on the 2nd word → err=1, remaining words and results still transfer.
- m_axis_tready held low for 10 cycles → tdata and tvalid stable, no further AR issued, busy stays 1.
- Assert rst during S_POLL_R → all valids 0 immediately, state S_IDLE. A new 1-word packet afterwards writes to address 0x0.
